// File: rtl/hack_screen_pkg.sv
// hack_screen_pkg: shared state encoding and default geometry for the Hack screen scanner
package hack_screen_pkg;
  localparam int WORD_W = 16;
  localparam int BIT_W = $clog2(WORD_W);
  localparam int DEF_WORDS_PER_ROW = 32;
  localparam int DEF_ROWS = 256;
  localparam int DEF_ADDR_W = 13;
  typedef enum logic [1:0] {IDLE, REQ, LOAD, SHIFT} state_t;
endpackage

// File: rtl/hack_screen_scanner_if.sv
// hack_screen_scanner_if: screen RAM read port, pixel stream and frame control of the scanner
interface hack_screen_scanner_if import hack_screen_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic enable;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_rd;
  logic [WORD_W-1:0] ram_data;
  logic pix;
  logic pix_valid;
  logic pix_ready;
  logic pix_first;
  logic pix_eol;
  logic frame_done;
  modport master (
    input enable, ram_data, pix_ready,
    output ram_addr, ram_rd, pix, pix_valid, pix_first, pix_eol, frame_done
  );
  modport slave (
    output enable, ram_data, pix_ready,
    input ram_addr, ram_rd, pix, pix_valid, pix_first, pix_eol, frame_done
  );
endinterface

// File: rtl/hack_pixel_shifter.sv
// hack_pixel_shifter: holds one screen word and walks its bits from bit 0 (leftmost) to bit 15
module hack_pixel_shifter import hack_screen_pkg::*; (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] data,
  input  logic              adv,
  output logic              pix,
  output logic              first,
  output logic              last
);
  logic [WORD_W-1:0] sh;
  logic [BIT_W-1:0] idx;
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
      idx <= '0;
    end else if (load) begin
      sh <= data;
      idx <= '0;
    end else if (adv) begin
      idx <= idx + BIT_W'(1);
    end
  end
  assign pix = sh[idx];
  assign first = idx == '0;
  assign last = idx == BIT_W'(WORD_W - 1);
endmodule

// File: rtl/hack_screen_scanner.sv
// hack_screen_scanner: reads the Hack screen RAM word by word and streams it out one pixel per transfer.
// Define HACK_SCREEN_PREFETCH_EN to prefetch the next word into a holding register for gap-free output.
module hack_screen_scanner import hack_screen_pkg::*; #(
  parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int ROWS = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic reset,
  hack_screen_scanner_if.master bus
);
  localparam int COL_W = WORDS_PER_ROW > 1 ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS_PER_ROW * ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WORDS_PER_ROW - 1);
  state_t state, state_n;
  logic [ADDR_W-1:0] cur;
  logic [COL_W-1:0] col;
  logic [WORD_W-1:0] ld_data;
  logic done, load, take, end_word, last_word;
  logic sh_pix, sh_first, sh_last;
  assign take = state == SHIFT && bus.pix_ready;
  assign end_word = take && sh_last;
  assign last_word = cur == LAST;
`ifdef HACK_SCREEN_PREFETCH_EN
  localparam state_t WORD_NEXT = SHIFT;
  logic pf_rd, pf_got;
  logic [WORD_W-1:0] hold;
  // next word is requested the cycle after the shifter takes a new word, so it lands long before bit 15
  always_ff @(posedge clk) begin
    if (reset) begin
      pf_rd <= 1'b0;
      pf_got <= 1'b0;
      hold <= '0;
    end else begin
      pf_rd <= (state == LOAD && !last_word) || (end_word && !last_word && cur + ADDR_W'(1) != LAST);
      pf_got <= pf_rd;
      if (pf_got) hold <= bus.ram_data;
    end
  end
  assign load = state == LOAD || (end_word && !last_word);
  assign ld_data = state == LOAD ? bus.ram_data : hold;
  assign bus.ram_rd = state == REQ || pf_rd;
  assign bus.ram_addr = state == SHIFT ? cur + ADDR_W'(1) : cur;
`else
  localparam state_t WORD_NEXT = REQ;
  assign load = state == LOAD;
  assign ld_data = bus.ram_data;
  assign bus.ram_rd = state == REQ;
  assign bus.ram_addr = cur;
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE  ? (bus.enable ? REQ : IDLE) :
              state == REQ   ? LOAD :
              state == LOAD  ? SHIFT :
              !end_word      ? SHIFT :
              last_word      ? IDLE : WORD_NEXT;
  end
  // cur/col follow the word in the shifter; both return to 0 when the frame ends
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      col <= '0;
      done <= 1'b0;
    end else begin
      done <= end_word && last_word;
      if (end_word) begin
        cur <= last_word ? '0 : cur + ADDR_W'(1);
        col <= col == COL_LAST ? '0 : col + COL_W'(1);
      end
    end
  end
  hack_pixel_shifter u_shift (
    .clk(clk),
    .reset(reset),
    .load(load),
    .data(ld_data),
    .adv(take),
    .pix(sh_pix),
    .first(sh_first),
    .last(sh_last)
  );
  assign bus.pix_valid = state == SHIFT;
  assign bus.pix = state == SHIFT && sh_pix;
  assign bus.pix_first = state == SHIFT && sh_first && cur == '0;
  assign bus.pix_eol = state == SHIFT && sh_last && col == COL_LAST;
  assign bus.frame_done = done;
endmodule

// File: tb/tb_hack_screen_scanner.sv
// tb_hack_screen_scanner: scoreboard bench for hack_screen_scanner on a 2-row, 2-words-per-row screen
module tb_hack_screen_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  hack_screen_scanner_if #(.ADDR_W(13)) bus();
  hack_screen_scanner #(.WORDS_PER_ROW(2), .ROWS(2), .ADDR_W(13)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );
`ifdef HACK_SCREEN_PREFETCH_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 2;
`endif
  logic [15:0] mem [4];
  logic [2:0] exp_q[$];
  int rd_log[$];
  int total = 0;
  int passed = 0;
  int mon_idx = 0;
  int gap = 0;
  bit prev_stall = 0;
  bit done_exp = 0;

  always @(posedge clk) if (bus.ram_rd) bus.ram_data <= mem[bus.ram_addr[1:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.ram_addr, bus.ram_rd, bus.pix, bus.pix_valid, bus.pix_first, bus.pix_eol, bus.frame_done});
  endfunction

  task automatic push_frame();
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 16; b++)
        exp_q.push_back({mem[w][b], w == 0 && b == 0, b == 15 && w % 2 == 1});
  endtask

  task automatic check_log(input string name);
    check({name, "_count"}, rd_log.size(), 4);
    foreach (rd_log[i]) check($sformatf("%s_addr%0d", name, i), rd_log[i], i);
    rd_log.delete();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!bus.frame_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, bus.frame_done, 1);
  endtask

  task automatic wait_idx(input string name, input int target);
    int n = 0;
    while (mon_idx != target && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, mon_idx, target);
  endtask

  // monitor: pops the scoreboard on every transfer, checks holds, gaps, reads and frame_done
  always @(negedge clk) begin
    if (reset) begin
      mon_idx = 0;
      gap = 0;
      prev_stall = 0;
      done_exp = 0;
    end else begin
      if (done_exp || bus.frame_done) check("frame_done_pulse", bus.frame_done, done_exp);
      done_exp = 0;
      if (prev_stall) check("stall_valid", bus.pix_valid, 1);
      prev_stall = bus.pix_valid && !bus.pix_ready;
      if (prev_stall && exp_q.size() > 0)
        check("stall_pix", {bus.pix, bus.pix_first, bus.pix_eol}, exp_q[0]);
      if (bus.ram_rd) rd_log.push_back(int'(bus.ram_addr));
      if (bus.pix_valid && bus.pix_ready) begin
        if (mon_idx % 16 == 0 && mon_idx != 0) check($sformatf("word_gap%0d", mon_idx), gap, EXP_GAP);
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_pix: pixel %0d transferred, expected none", mon_idx);
        end else begin
          check($sformatf("pix%0d", mon_idx), {bus.pix, bus.pix_first, bus.pix_eol}, exp_q.pop_front());
        end
        gap = 0;
        done_exp = mon_idx == 63;
        mon_idx = (mon_idx + 1) % 64;
      end else if (!bus.pix_valid && mon_idx != 0) begin
        gap++;
      end
    end
  end

  initial begin
    bus.enable = 1'b0;
    bus.pix_ready = 1'b1;
    mem = '{16'h0001, 16'hFFFF, 16'h0000, 16'h1234};
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 0);
    reset = 1'b0;
    bus.enable = 1'b1;
    push_frame();
    @(posedge clk); #1;
    check("start_rd", {bus.ram_rd, bus.ram_addr}, {1'b1, 13'd0});
    @(posedge clk); #1;
    check("start_load", {bus.pix_valid, bus.ram_rd}, 0);
    @(posedge clk); #1;
    check("start_pix", {bus.pix_valid, bus.pix, bus.pix_first}, 3'b111);
    bus.enable = 1'b0;
    wait_done("frame1_done");
    check_log("frame1_reads");
    repeat (5) @(posedge clk);
    #1;
    check("idle_after", {bus.pix_valid, bus.ram_rd, bus.frame_done}, 0);
    check("no_extra_reads", rd_log.size(), 0);
    mem = '{16'hA5A5, 16'h8001, 16'h7FFE, 16'hC003};
    bus.enable = 1'b1;
    push_frame();
    wait_idx("bp_reach", 4);
    bus.pix_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.pix_ready = 1'b1;
    wait_done("frame2_done");
    check_log("frame2_reads");
    push_frame();
    @(posedge clk); #1;
    check("next_frame_rd", {bus.ram_rd, bus.ram_addr}, {1'b1, 13'd0});
    wait_idx("mid_reach", 40);
    reset = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check("reset_mid", outs(), 0);
    exp_q.delete();
    rd_log.delete();
    reset = 1'b0;
    bus.enable = 1'b1;
    push_frame();
    @(posedge clk); #1;
    check("reset_restart_rd", {bus.ram_rd, bus.ram_addr}, {1'b1, 13'd0});
    bus.enable = 1'b0;
    wait_done("frame4_done");
    check_log("frame4_reads");
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("final_idle", {bus.pix_valid, bus.ram_rd}, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
